// File: rtl/sram_responder.sv
// -----------------------------------------------------------------------------
// sram_responder
//
// Behavioural-but-synthesizable stand-in for the off-chip asynchronous SRAM
// seen by the LC-3 datapath. Reads complete after a programmable number of
// clock edges. Writes honour the UB/LB byte-lane selects. A host preload port
// loads program images while the chip is deselected.
//
// Parameters
//   ADDR_W   : implemented word-address bits (DEPTH = 2**ADDR_W words).
//              Higher ADDR bits alias.
//   READ_LAT : edges from read qualification to Data being driven (1..7).
//
// Ports
//   Clk        in   system clock, rising edge
//   Reset      in   asynchronous reset, active-low
//   CE/OE/WE   in   chip / output / write enable, active-low
//   UB/LB      in   upper / lower byte-lane select, active-low
//   ADDR       in   20-bit word address, only [ADDR_W-1:0] decoded
//   Data       io   16-bit shared data bus, driven only in RD_DRIVE
//   Init_We    in   preload write strobe, active-high, accepted when CE=1
//   Init_Addr  in   preload word address
//   Init_Data  in   preload data (full word)
//   Init_Ack   out  one-cycle pulse after an accepted preload write
//   Rd_Valid   out  high while Data carries valid read data
//   Conflict   out  sticky bus-misuse flag, present only when
//                   SRAM_CONFLICT_FLAG_EN is defined
//
// Optional feature macro: SRAM_CONFLICT_FLAG_EN
// -----------------------------------------------------------------------------
module sram_responder #(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              CE,
    input  logic              OE,
    input  logic              WE,
    input  logic              UB,
    input  logic              LB,
    input  logic [19:0]       ADDR,
    inout  wire  [15:0]       Data,
    input  logic              Init_We,
    input  logic [ADDR_W-1:0] Init_Addr,
    input  logic [15:0]       Init_Data,
    output logic              Init_Ack,
    output logic              Rd_Valid
`ifdef SRAM_CONFLICT_FLAG_EN
    ,
    output logic              Conflict
`endif
);

    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [2:0] LAT_LOAD = 3'(READ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_DRIVE = 2'd2
    } state_t;

    state_t            state_r;
    logic [2:0]        cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [15:0]       rdata_r;
    logic              init_ack_r;
    logic [15:0]       mem_r [DEPTH];

    logic              write_s;
    logic              read_s;
    logic [ADDR_W-1:0] addr_s;
    logic              same_addr_s;
    logic              launch_s;
    logic              drive_ok_s;
    logic              unused_addr_s;

    // Bus decode: WE low wins over OE low, so a write is never a read.
    assign write_s     = !CE && !WE;
    assign read_s      = !CE && WE && !OE;
    assign addr_s      = ADDR[ADDR_W-1:0];
    assign same_addr_s = (addr_s == addr_r);

    // Upper address bits are aliased away on purpose.
    assign unused_addr_s = ^ADDR[19:ADDR_W];

    // A read (re)starts from IDLE, or from any read state when ADDR moves.
    assign launch_s = read_s && ((state_r == IDLE) || !same_addr_s);

    // Data is only valid while the read it belongs to is still on the bus;
    // dropping READ or moving ADDR releases the lanes without waiting for an edge.
    assign drive_ok_s = (state_r == RD_DRIVE) && read_s && same_addr_s;
    assign Rd_Valid   = drive_ok_s;
    assign Init_Ack   = init_ack_r;

    assign Data[15:8] = (drive_ok_s && !UB) ? rdata_r[15:8] : 8'hzz;
    assign Data[7:0]  = (drive_ok_s && !LB) ? rdata_r[7:0]  : 8'hzz;

    // Read sequencing FSM: latency countdown, read-data capture, abort handling.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
            addr_r  <= '0;
            rdata_r <= 16'h0000;
        end else if (launch_s) begin
            addr_r <= addr_s;
            if (READ_LAT == 1) begin
                state_r <= RD_DRIVE;
                cnt_r   <= 3'd0;
                rdata_r <= mem_r[addr_s];
            end else begin
                state_r <= RD_WAIT;
                cnt_r   <= LAT_LOAD;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= IDLE;
                end
                RD_WAIT: begin
                    // Any WRITE also clears read_s, so this covers write abort.
                    if (!read_s) begin
                        state_r <= IDLE;
                        cnt_r   <= 3'd0;
                    end else if (cnt_r <= 3'd1) begin
                        // Final wait edge: capture now so Data appears after
                        // exactly READ_LAT edges from qualification.
                        state_r <= RD_DRIVE;
                        cnt_r   <= 3'd0;
                        rdata_r <= mem_r[addr_r];
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                RD_DRIVE: begin
                    if (!read_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= RD_DRIVE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 3'd0;
                end
            endcase
        end
    end

    // Storage array: bus byte-lane writes, else host preload while deselected.
    // Contents deliberately survive reset.
    always_ff @(posedge Clk) begin
        if (write_s) begin
            if (!UB) begin
                mem_r[addr_s][15:8] <= Data[15:8];
            end
            if (!LB) begin
                mem_r[addr_s][7:0] <= Data[7:0];
            end
        end else if (Init_We && CE) begin
            mem_r[Init_Addr] <= Init_Data;
        end
    end

    // Preload handshake: acknowledge the cycle after an accepted strobe.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            init_ack_r <= 1'b0;
        end else begin
            init_ack_r <= Init_We && CE;
        end
    end

`ifdef SRAM_CONFLICT_FLAG_EN
    logic conflict_r;

    // Sticky misuse flag: WE and OE both low, or preload attempted while selected.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            conflict_r <= 1'b0;
        end else if ((!CE && !WE && !OE) || (Init_We && !CE)) begin
            conflict_r <= 1'b1;
        end else begin
            conflict_r <= conflict_r;
        end
    end

    assign Conflict = conflict_r;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_sram_responder
//
// Directed bench for sram_responder with default parameters
// (ADDR_W=10, READ_LAT=2). Lanes that should be released by the DUT are held
// by the bench at a background pattern, so a lane the DUT wrongly drives
// shows up as a corrupted background value.
// -----------------------------------------------------------------------------
module tb_sram_responder;

    logic        clk;
    logic        rst_n;
    logic        ce, oe, we, ub, lb;
    logic [19:0] addr;
    logic        init_we;
    logic [9:0]  init_addr;
    logic [15:0] init_data;
    logic        init_ack;
    logic        rd_valid;
    wire  [15:0] data_w;
`ifdef SRAM_CONFLICT_FLAG_EN
    logic        conflict;
`endif

    logic        hi_en, lo_en;
    logic [7:0]  hi_drv, lo_drv;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [7:0] BG_HI = 8'hA5;
    localparam logic [7:0] BG_LO = 8'h5A;

    assign data_w[15:8] = hi_en ? hi_drv : 8'hzz;
    assign data_w[7:0]  = lo_en ? lo_drv : 8'hzz;

    sram_responder dut (
        .Clk       (clk),
        .Reset     (rst_n),
        .CE        (ce),
        .OE        (oe),
        .WE        (we),
        .UB        (ub),
        .LB        (lb),
        .ADDR      (addr),
        .Data      (data_w),
        .Init_We   (init_we),
        .Init_Addr (init_addr),
        .Init_Data (init_data),
        .Init_Ack  (init_ack),
        .Rd_Valid  (rd_valid)
`ifdef SRAM_CONFLICT_FLAG_EN
        ,
        .Conflict  (conflict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check Rd_Valid and bus contents; released lanes must read back background.
    task automatic expect_bus(input string tag, input logic exp_valid,
                              input logic hi_on, input logic lo_on, input logic [15:0] word);
        logic [15:0] exp_w;
        hi_en  = !hi_on;
        lo_en  = !lo_on;
        hi_drv = BG_HI;
        lo_drv = BG_LO;
        exp_w  = {hi_on ? word[15:8] : BG_HI, lo_on ? word[7:0] : BG_LO};
        #1;
        check_eq({tag, "_valid"}, {31'd0, rd_valid}, {31'd0, exp_valid});
        check_eq({tag, "_data"}, {16'd0, data_w}, {16'd0, exp_w});
        hi_en = 1'b0;
        lo_en = 1'b0;
    endtask

    task automatic bus_idle();
        ce = 1'b1; oe = 1'b1; we = 1'b1; ub = 1'b1; lb = 1'b1;
        hi_en = 1'b0; lo_en = 1'b0;
    endtask

    task automatic preload(input logic [9:0] a, input logic [15:0] d);
        init_we = 1'b1; init_addr = a; init_data = d;
        tick();
        init_we = 1'b0;
        check_eq("preload_ack", {31'd0, init_ack}, 32'd1);
        tick();
        check_eq("preload_ack_pulse", {31'd0, init_ack}, 32'd0);
    endtask

    task automatic bus_write(input logic [19:0] a, input logic [15:0] d,
                             input logic u, input logic l);
        ce = 1'b0; we = 1'b0; oe = 1'b1; ub = u; lb = l; addr = a;
        hi_en = 1'b1; lo_en = 1'b1; hi_drv = d[15:8]; lo_drv = d[7:0];
        tick();
        we = 1'b1;
        hi_en = 1'b0; lo_en = 1'b0;
    endtask

    task automatic start_read(input logic [19:0] a);
        ce = 1'b0; we = 1'b1; oe = 1'b0; ub = 1'b0; lb = 1'b0; addr = a;
    endtask

    initial begin
        rst_n = 1'b0;
        addr = 20'd0; init_we = 1'b0; init_addr = 10'd0; init_data = 16'h0000;
        hi_drv = 8'h00; lo_drv = 8'h00;
        bus_idle();
        #2;
        check_eq("rst_valid", {31'd0, rd_valid}, 32'd0);
        check_eq("rst_ack", {31'd0, init_ack}, 32'd0);
`ifdef SRAM_CONFLICT_FLAG_EN
        check_eq("rst_conflict", {31'd0, conflict}, 32'd0);
`endif
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1: preload then read with READ_LAT=2
        preload(10'd3, 16'h1234);
        preload(10'd5, 16'hAAAA);
        start_read(20'd3);
        expect_bus("t1_pre", 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        expect_bus("t1_e1", 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        expect_bus("t1_e2", 1'b1, 1'b1, 1'b1, 16'h1234);

        // 3: upper lane masked while driving
        ub = 1'b1;
        expect_bus("t3_mask", 1'b1, 1'b0, 1'b1, 16'h1234);
        ub = 1'b0;
        bus_idle();
        expect_bus("t3_release", 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();

        // 2: lower-lane write then read-after-write
        bus_write(20'd5, 16'h1234, 1'b1, 1'b0);
        start_read(20'd5);
        tick();
        tick();
        expect_bus("t2_lane", 1'b1, 1'b1, 1'b1, 16'hAA34);

        // 4a: ADDR moves away in RD_DRIVE, then 3->5 in RD_WAIT
        addr = 20'd3;
        expect_bus("t4_comb_release", 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        addr = 20'd5;
        expect_bus("t4_wait", 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        expect_bus("t4_e1", 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        expect_bus("t4_e2", 1'b1, 1'b1, 1'b1, 16'hAA34);

        // 4b: asynchronous reset in RD_DRIVE
        #2;
        rst_n = 1'b0;
        expect_bus("t4_reset", 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        rst_n = 1'b1;
        tick();
        expect_bus("t4_after_rst_e1", 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        expect_bus("t4_after_rst_e2", 1'b1, 1'b1, 1'b1, 16'hAA34);
        bus_idle();
        tick();

        // 5: write wins over OE, DUT keeps off the bus; preload rejected when CE=0
        ce = 1'b0; we = 1'b0; oe = 1'b0; ub = 1'b0; lb = 1'b0; addr = 20'd7;
        hi_en = 1'b1; lo_en = 1'b1; hi_drv = 8'hBE; lo_drv = 8'hEF;
        #1;
        check_eq("t5_nodrive", {16'd0, data_w}, 32'h0000BEEF);
        tick();
        check_eq("t5_nodrive_edge", {16'd0, data_w}, 32'h0000BEEF);
        check_eq("t5_valid", {31'd0, rd_valid}, 32'd0);
        we = 1'b1; oe = 1'b1; hi_en = 1'b0; lo_en = 1'b0;
        init_we = 1'b1; init_addr = 10'd7; init_data = 16'h1111;
        tick();
        check_eq("t5_ack0", {31'd0, init_ack}, 32'd0);
        tick();
        check_eq("t5_ack1", {31'd0, init_ack}, 32'd0);
        init_we = 1'b0;
        start_read(20'd7);
        tick();
        tick();
        expect_bus("t5_mem7", 1'b1, 1'b1, 1'b1, 16'hBEEF);
`ifdef SRAM_CONFLICT_FLAG_EN
        check_eq("t5_conflict", {31'd0, conflict}, 32'd1);
`endif
        bus_idle();
        tick();

        // 6: aliasing, plus a write with both lanes deselected
        bus_write(20'h00400, 16'h00F0, 1'b0, 1'b0);
        bus_write(20'h00000, 16'hFFFF, 1'b1, 1'b1);
        start_read(20'd0);
        tick();
        tick();
        expect_bus("t6_alias", 1'b1, 1'b1, 1'b1, 16'h00F0);
`ifdef SRAM_CONFLICT_FLAG_EN
        check_eq("t6_conflict_sticky", {31'd0, conflict}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_conflict_clr", {31'd0, conflict}, 32'd0);
        rst_n = 1'b1;
`endif
        bus_idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Synthesizable responder for the CPU-side asynchronous-SRAM bus driven by the LC-3 datapath: CE, OE, WE, UB and LB, all active-low, plus ADDR[19:0] and a bidirectional Data[15:0].
- Stands in for the off-chip SRAM in simulation and on-chip builds, with configurable read latency and byte-lane writes.
- A host preload port loads program images while the bus is idle.

Parameters:
- ADDR_W, 10: implemented word-address bits; DEPTH = 2**ADDR_W words.
- READ_LAT, 2: clock cycles from read qualification to Data being driven; legal range 1..7.

Ports:
- Clk, in, 1: system clock, rising edge.
- Reset, in, 1: asynchronous, active-low reset.
- CE, in, 1: chip enable, active-low.
- OE, in, 1: output enable, active-low.
- WE, in, 1: write enable, active-low.
- UB, in, 1: upper byte lane Data[15:8] select, active-low.
- LB, in, 1: lower byte lane Data[7:0] select, active-low.
- ADDR, in, 20: word address; bits above ADDR_W-1 are ignored (aliased).
- Data, inout, 16: shared data bus, driven by this block only during a completed read.
- Init_We, in, 1: host preload write strobe, active-high.
- Init_Addr, in, ADDR_W: preload word address.
- Init_Data, in, 16: preload data; always written as a full word.
- Init_Ack, out, 1: one-cycle pulse when a preload write is accepted.
- Rd_Valid, out, 1: high while Data is driven with valid read data.

Behaviour:
- Reset (asynchronous, Reset=0) forces the following immediately, including mid-read:
  - state IDLE, latency counter 0;
  - Data released to Z on both lanes;
  - Rd_Valid=0, Init_Ack=0.
- Memory array contents are not reset.
- Bus decode, sampled each rising edge:
  - WRITE = CE=0 & WE=0.
  - READ = CE=0 & WE=1 & OE=0.
  - WE=0 has priority over OE=0. Data is never driven while WE=0, so there is no contention.
- State machine: IDLE, RD_WAIT, RD_DRIVE.
- IDLE:
  - on READ, latch ADDR[ADDR_W-1:0], load counter with READ_LAT-1, go to RD_WAIT.
  - if READ_LAT=1, go directly to RD_DRIVE.
- RD_WAIT:
  - decrement counter each cycle; at 0, register the array word and go to RD_DRIVE.
  - leaving READ (CE, OE or WE deasserting) returns to IDLE with no drive.
  - an ADDR change restarts the wait with the new address.
- RD_DRIVE:
  - Rd_Valid=1; Data[15:8] is driven only when UB=0, Data[7:0] only when LB=0, otherwise that lane is Z.
  - lanes follow UB/LB combinationally while in RD_DRIVE.
  - an ADDR change returns to RD_WAIT and releases Data the same cycle (combinational release).
  - READ deasserting returns to IDLE and releases Data combinationally.
- Total read latency: Data valid READ_LAT rising edges after the first edge at which READ is sampled with stable ADDR.
- Write:
  - on each rising edge with WRITE true, mem[ADDR] lane [15:8] <= Data[15:8] if UB=0, lane [7:0] <= Data[7:0] if LB=0.
  - both UB and LB high means no write.
  - a WRITE held over multiple cycles rewrites each cycle (idempotent).
  - a WRITE arriving during RD_WAIT or RD_DRIVE aborts the read (go to IDLE, release Data) and commits the same edge.
- Read-after-write: a READ one cycle after a WRITE to the same address returns the new data.
- Preload:
  - Init_We is accepted only on an edge where CE=1: writes mem[Init_Addr] <= Init_Data, and Init_Ack=1 the following cycle.
  - when CE=0, Init_We is ignored and Init_Ack stays 0; the host holds Init_We until it sees Init_Ack.
- Addressing: addresses >= DEPTH alias modulo DEPTH; there is no error response.

Optional Feature:
- Macro SRAM_CONFLICT_FLAG_EN.
- Defined:
  - adds output port Conflict (1 bit), a sticky flag cleared only by Reset.
  - Conflict is set on any edge where CE=0 & WE=0 & OE=0, or where Init_We=1 & CE=0.
  - write priority is unchanged.
- Undefined: the port is absent and the logic is not synthesized. Functional behaviour is otherwise identical.

Test Plan:
1. Preload, then read:
   - stimulus: Reset pulse low; CE=1; Init_We with Init_Addr=3, Init_Data=16'h1234; then CE=0, OE=0, WE=1, UB=0, LB=0, ADDR=3.
   - response: Init_Ack pulses for one cycle; Data=16'h1234 with Rd_Valid=1 exactly 2 edges after READ is sampled; Data is Z before that.
2. Byte-lane write:
   - stimulus: mem[5]=16'hAAAA; write 16'h1234 to ADDR 5 with UB=1, LB=0; then full-word read of ADDR 5.
   - response: read returns 16'hAA34.
3. Read with a masked lane:
   - stimulus: read ADDR 3 with UB=1, LB=0.
   - response: Data[15:8]=Z, Data[7:0]=8'h34.
4. Mid-read address change and reset:
   - stimulus: ADDR changes 3 to 5 during RD_WAIT; separately, Reset=0 asserted during RD_DRIVE.
   - response: for the address change, Data shows mem[5] 2 edges after the change and never shows mem[3]; for the reset, Data goes Z and Rd_Valid=0 with no clock edge.
5. Write priority and rejected preload:
   - stimulus: CE=0, WE=0, OE=0 with Data=16'hBEEF at ADDR 7; then Init_We=1 while CE=0.
   - response: mem[7]=16'hBEEF and Data is not driven by the block; Init_Ack stays 0; with SRAM_CONFLICT_FLAG_EN defined, Conflict=1 and stays set until Reset.
6. Aliasing:
   - stimulus: write 16'h00F0 at ADDR 20'h00400 with ADDR_W=10; read ADDR 0.
   - response: read returns 16'h00F0.
